bcd_counter_multi: RTL and testbench
====================================

// Module: bcd_counter_multi
// PURPOSE
//  - Parametrised multi-digit BCD up/down counter; next generation of the single-digit mod-10 counter.
//  - Adds N cascaded decades, direction control, count enable, parallel load and carry/borrow signalling.
//  - Feeds display/timekeeping logic; carry_out chains to further counters.
// PARAMETERS
//  - DIGITS     4  number of BCD decades; count width = 4*DIGITS; legal 1..8
//  - RESET_VAL  0  {4*DIGITS} BCD value applied on clear_n and sync_clear; every nibble must be <= 9
// PORTS
//  - clock       in   1         rising-edge clock; the block has one clock
//  - clear_n     in   1         asynchronous, active-low reset
//  - sync_clear  in   1         synchronous clear to RESET_VAL
//  - en          in   1         count enable
//  - up_dn       in   1         1 = count up, 0 = count down; sampled only when en=1
//  - load        in   1         synchronous parallel load request
//  - load_val    in   4*DIGITS  BCD value to load; digit 0 = bits [3:0]
//  - count       out  4*DIGITS  registered BCD count
//  - carry_out   out  1         registered 1-cycle pulse on wrap (9..9->0..0 up, 0..0->9..9 down)
//  - at_max      out  1         combinational; count == all 9s
//  - at_min      out  1         combinational; count == 0
//  - load_err    out  1         registered 1-cycle pulse when a load is rejected
// BEHAVIOUR
//  - Reset (clear_n=0, async): count=RESET_VAL, carry_out=0, load_err=0; held while low; release is synchronous to the next edge.
//  - Per-edge priority: sync_clear > load > en > hold.
//  - sync_clear: count<=RESET_VAL; carry_out<=0; load_err<=0.
//  - load: every load_val nibble <= 9 -> count<=load_val, load_err<=0.
//    Any nibble > 9 -> count holds, load_err<=1 for one cycle.
//    load never asserts carry_out.
//  - en=1, up_dn=1:
//    - Digit i increments iff digits 0..i-1 are all 9.
//    - A digit at 9 that increments becomes 0.
//  - en=1, up_dn=0:
//    - Digit i decrements iff digits 0..i-1 are all 0.
//    - A digit at 0 that decrements becomes 9.
//  - Count latency: 1 clock; count shows the new value after the edge at which en is sampled.
//  - carry_out: asserted in the same cycle as the wrapped count value (1 for exactly one cycle).
//    - Deasserts the next cycle unless another wrap occurs.
//    - With DIGITS=1 and continuous en: one pulse per 10 clocks.
//  - Direction change mid-count: takes effect at the next enabled edge; no extra state is kept.
//  - en=0 with no load or sync_clear: count holds; carry_out<=0.
//  - Count is always valid BCD: no nibble > 9 is reachable from reset, count or load.
// CONFIGURATION
//  - Macro BCD_COUNTER_MULTI_SATURATE_EN.
//  - Defined:
//    - Up count at all 9s holds at all 9s; down count at 0 holds at 0.
//    - carry_out is tied 0.
//    - Load and clear are unchanged.
//  - Undefined (default): wrap-around and carry_out as described in BEHAVIOUR.
// TESTING
//  - DIGITS=2; reset, en=1, up_dn=1, 100 clocks -> count 00..99 then 00; carry_out high only with the 00 after 99.
//  - DIGITS=2; load 8'h10, en=1, up_dn=0 -> 09, 08..00, 99; carry_out high with 99.
//  - load_val=8'h3A -> count holds, load_err 1 cycle; then load_val=8'h42 -> count 42, load_err 0.
//  - count=17 while counting, assert clear_n=0 between edges -> count = RESET_VAL immediately; outputs 0 until release.
//  - Same edge: sync_clear=1, load=1, en=1 -> RESET_VAL; then load=1, en=1 -> load_val (load wins).
//  - With BCD_COUNTER_MULTI_SATURATE_EN: from 99 count up 3 clocks -> stays 99, carry_out 0; from 00 count down -> stays 00.

Source files
------------

// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: parametrised multi-decade BCD up/down counter with
// count enable, parallel load (with BCD validity check) and carry/borrow
// pulse. Optional build macro BCD_COUNTER_MULTI_SATURATE_EN makes the
// counter stop at all-9s (up) / all-0s (down) and ties carry_out low.

// Per-decade next value and terminal flags; step says whether this decade
// moves on the current enabled edge.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       step,
  output logic [3:0] nxt,
  output logic       is9,
  output logic       is0
);
  assign is9 = (d == 4'd9);
  assign is0 = (d == 4'd0);

  // Increment/decrement with decade wrap when this digit is stepped
  always_comb begin
    nxt = d;
    if (step) begin
      if (up) nxt = is9 ? 4'd0 : d + 4'd1;
      else    nxt = is0 ? 4'd9 : d - 4'd1;
    end
  end
endmodule

module bcd_counter_multi #(
  parameter int                    DIGITS    = 4,
  parameter logic [4*DIGITS-1:0]   RESET_VAL = '0
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  sync_clear,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  load_err
);
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, cnt_step;
  logic [DIGITS:0]        step;
  logic [DIGITS-1:0]      is9, is0, nib_ok;
  logic                   wrap, ld_ok, cy_d, le_d;

  // Decade i moves iff every lower decade is at its terminal value for the
  // current direction; step[DIGITS] is therefore the whole-counter wrap.
  assign step[0] = 1'b1;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .d    (cnt_q[g]),
        .up   (up_dn),
        .step (step[g]),
        .nxt  (cnt_step[g]),
        .is9  (is9[g]),
        .is0  (is0[g])
      );
      assign step[g+1] = step[g] & (up_dn ? is9[g] : is0[g]);
      assign nib_ok[g] = (load_val[4*g +: 4] <= 4'd9);
    end
  endgenerate

  assign wrap   = step[DIGITS];
  assign ld_ok  = &nib_ok;
  assign count  = cnt_q;
  assign at_max = &is9;
  assign at_min = &is0;

  // Next state: sync_clear > load > en > hold; pulses default low
  always_comb begin
    cnt_d = cnt_q;
    cy_d  = 1'b0;
    le_d  = 1'b0;
    if (sync_clear) begin
      cnt_d = RESET_VAL;
    end else if (load) begin
      if (ld_ok) cnt_d = load_val;
      else       le_d  = 1'b1;
    end else if (en) begin
`ifdef BCD_COUNTER_MULTI_SATURATE_EN
      if (!wrap) cnt_d = cnt_step;
`else
      cnt_d = cnt_step;
      cy_d  = wrap;
`endif
    end
  end

  // Count and pulse registers, async clear to RESET_VAL
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q     <= RESET_VAL;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      carry_out <= cy_d;
      load_err  <= le_d;
    end
  end
endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench for bcd_counter_multi with DIGITS=2, RESET_VAL=00.
module tb_bcd_counter_multi;
`ifdef BCD_COUNTER_MULTI_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       sync_clear = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic       carry_out, at_max, at_min, load_err;

  bcd_counter_multi #(.DIGITS(2), .RESET_VAL(8'h00)) dut (
    .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear), .en(en),
    .up_dn(up_dn), .load(load), .load_val(load_val), .count(count),
    .carry_out(carry_out), .at_max(at_max), .at_min(at_min), .load_err(load_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       cy;
    logic       le;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         ncmp = 0;
  int         nerr = 0;
  logic [7:0] cur = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Monitor: compare every expectation whose target edge has just occurred
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc < cyc) begin
          nerr++;
          $display("FAIL stale_expectation: target %0d checked at %0d", e.cyc, cyc);
        end else begin
          chk("count",     count,           e.cnt);
          chk("carry_out", {7'd0, carry_out}, {7'd0, e.cy});
          chk("load_err",  {7'd0, load_err},  {7'd0, e.le});
          chk("at_max",    {7'd0, at_max},    {7'd0, (e.cnt == 8'h99)});
          chk("at_min",    {7'd0, at_min},    {7'd0, (e.cnt == 8'h00)});
        end
      end
    end
  end

  // Apply one edge's inputs and queue the state expected after that edge
  task automatic drive(input logic sc, input logic ld, input logic [7:0] lv,
                       input logic e, input logic ud,
                       input logic [7:0] ec, input logic ecy, input logic ele);
    exp_t x;
    @(posedge clock);
    #1;
    sync_clear = sc; load = ld; load_val = lv; en = e; up_dn = ud;
    x.cyc = cyc + 1; x.cnt = ec; x.cy = ecy; x.le = ele;
    q.push_back(x);
    cur = ec;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state while clear_n is held low
    repeat (2) @(posedge clock);
    #3;
    chk("rst_count", count, 8'h00);
    chk("rst_carry", {7'd0, carry_out}, 8'h00);
    chk("rst_lerr",  {7'd0, load_err},  8'h00);
    chk("rst_at_min", {7'd0, at_min}, 8'h01);
    @(negedge clock);
    clear_n = 1'b1;

    // Up count 01..99 then 00 with carry (saturating: holds 99)
    for (int i = 1; i <= 100; i++)
      drive(0, 0, 8'h00, 1, 1,
            (SAT && i == 100) ? 8'h99 : bcd(i % 100), !SAT && i == 100, 0);
    drive(0, 0, 8'h00, 0, 1, cur, 0, 0);

    // Load 10 then count down 09..00, then wrap to 99
    drive(0, 1, 8'h10, 0, 0, 8'h10, 0, 0);
    for (int i = 1; i <= 11; i++)
      drive(0, 0, 8'h00, 1, 0,
            (i == 11) ? (SAT ? 8'h00 : 8'h99) : bcd(10 - i), !SAT && i == 11, 0);
    drive(0, 0, 8'h00, 0, 0, cur, 0, 0);

    // Invalid load (low nibble) rejected, then a valid one accepted
    drive(0, 1, 8'h3A, 0, 0, cur, 0, 1);
    drive(0, 1, 8'h42, 0, 0, 8'h42, 0, 0);
    // Invalid high nibble, then hold clears load_err
    drive(0, 1, 8'hA0, 1, 1, 8'h42, 0, 1);
    drive(0, 0, 8'h00, 0, 1, 8'h42, 0, 0);

    // Inter-decade carry and borrow without whole-counter wrap
    drive(0, 1, 8'h19, 0, 0, 8'h19, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 8'h20, 0, 0);
    drive(0, 0, 8'h00, 1, 0, 8'h19, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 8'h20, 0, 0);

    // Count to 17, then async clear between edges
    drive(0, 1, 8'h15, 0, 0, 8'h15, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 8'h16, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 8'h17, 0, 0);
    @(posedge clock);
    #3;
    en = 1'b0;
    clear_n = 1'b0;
    #1;
    chk("async_count", count, 8'h00);
    chk("async_carry", {7'd0, carry_out}, 8'h00);
    chk("async_lerr",  {7'd0, load_err},  8'h00);
    @(posedge clock);
    #3;
    chk("async_hold_count", count, 8'h00);
    @(negedge clock);
    clear_n = 1'b1;

    // Priority: sync_clear beats load and en; load beats en
    drive(0, 1, 8'h55, 0, 0, 8'h55, 0, 0);
    drive(1, 1, 8'h33, 1, 1, 8'h00, 0, 0);
    drive(0, 1, 8'h33, 1, 1, 8'h33, 0, 0);
    // Direction change takes effect on the next enabled edge
    drive(0, 0, 8'h00, 1, 0, 8'h32, 0, 0);
    drive(0, 0, 8'h00, 1, 1, 8'h33, 0, 0);
    // sync_clear while load_val is invalid gives no load_err
    drive(1, 1, 8'hFF, 0, 0, 8'h00, 0, 0);

    // Boundary from 99 up and from 00 down
    drive(0, 1, 8'h99, 0, 0, 8'h99, 0, 0);
    drive(0, 0, 8'h00, 1, 1, SAT ? 8'h99 : 8'h00, !SAT, 0);
    drive(0, 0, 8'h00, 1, 1, SAT ? 8'h99 : 8'h01, 0, 0);
    drive(0, 0, 8'h00, 1, 1, SAT ? 8'h99 : 8'h02, 0, 0);
    drive(0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 0, SAT ? 8'h00 : 8'h99, !SAT, 0);
    // Wrap pulse cleared by load on the following edge
    drive(0, 1, 8'h07, 1, 0, 8'h07, 0, 0);
    drive(0, 0, 8'h00, 0, 0, 8'h07, 0, 0);

    repeat (3) @(posedge clock);
    #3;
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
